// File: rtl/snd_wrqueue_if.sv
// snd_wrqueue_if: valid/ready handshake carrying queued sound writes
// Ports (master = queue, slave = sound module):
//   q_valid   head entry present
//   q_ready   consumer accepts the head this edge
//   q_datnvol 1 = sample write, 0 = volume write
//   q_addr    channel number (CW bits)
//   q_data    8-bit payload
interface snd_wrqueue_if #(
  parameter int CW = 3
);
  logic          q_valid;
  logic          q_ready;
  logic          q_datnvol;
  logic [CW-1:0] q_addr;
  logic [7:0]    q_data;
  modport master (output q_valid, q_datnvol, q_addr, q_data, input q_ready);
  modport slave (input q_valid, q_datnvol, q_addr, q_data, output q_ready);
endinterface

// File: rtl/snd_wrqueue.sv
// snd_wrqueue: decodes Z80 volume-port and sample-window writes into a DEPTH-entry FIFO
// Ports:
//   cpu_clock, rst_n            clock (rising edge) and async active-low reset
//   a, din                      Z80 address and data buses
//   iorq_n, mreq_n, rd_n, wr_n  Z80 control strobes, active low
//   mode_full                   0 restricts sample channels to the lower half
//   q                           head-of-queue handshake (master side)
//   q_level, full, empty        FIFO occupancy
//   ovf, ovf_clr                sticky overflow flag and its synchronous clear
module snd_wrqueue #(
  parameter int NCHAN = 8,
  parameter int DEPTH = 4,
  parameter logic [5:0] VOLBASE = 6'h06,
  localparam int CW = $clog2(NCHAN),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          cpu_clock,
  input  logic          rst_n,
  input  logic [15:0]   a,
  input  logic [7:0]    din,
  input  logic          iorq_n,
  input  logic          mreq_n,
  input  logic          rd_n,
  input  logic          wr_n,
  input  logic          mode_full,
  input  logic          ovf_clr,
  snd_wrqueue_if.master q,
  output logic [LW-1:0] q_level,
  output logic          full,
  output logic          empty,
  output logic          ovf
);
  localparam int PW = LW - 1;
  localparam logic [6:0] VOLEND = 7'(VOLBASE) + 7'(NCHAN);
  logic          prev_vw, prev_sw, vw, sw, vpush, spush, push, pop, wr;
  logic [5:0]    voff;
  logic [CW-1:0] sch;
  logic [CW+8:0] ent, head;
  logic [CW+8:0] mem [DEPTH];
  logic [PW-1:0] rp, wp;
  assign vw = ~iorq_n & ~wr_n & (a[7:6] == 2'b00) & (a[5:0] >= VOLBASE) & ({1'b0, a[5:0]} < VOLEND);
  assign sw = ~mreq_n & ~rd_n & (a[15:13] == 3'b011);
  // push only on the rising edge of each condition so wait states add nothing
  assign vpush = vw & ~prev_vw;
  assign spush = sw & ~prev_sw;
  assign push = vpush | spush;
  assign voff = a[5:0] - VOLBASE;
  assign sch = mode_full ? a[8 +: CW] : a[8 +: CW] & ~(CW'(1) << (CW - 1));
  // a simultaneous sample push wins; the volume entry is silently dropped
  assign ent = spush ? {1'b1, sch, din} : {1'b0, voff[CW-1:0], din};
  assign full = q_level == LW'(DEPTH);
  assign empty = q_level == '0;
  assign pop = ~empty & q.q_ready;
  assign wr = push & (~full | pop);
  assign head = mem[rp];
  assign q.q_valid = ~empty;
  assign {q.q_datnvol, q.q_addr, q.q_data} = empty ? '0 : head;
  always_ff @(posedge cpu_clock or negedge rst_n)
    if (!rst_n) begin
      prev_vw <= 1'b0;
      prev_sw <= 1'b0;
      rp <= '0;
      wp <= '0;
      q_level <= '0;
      ovf <= 1'b0;
    end else begin
      prev_vw <= vw;
      prev_sw <= sw;
      rp <= rp + PW'(pop);
      wp <= wp + PW'(wr);
      q_level <= q_level + LW'(wr) - LW'(pop);
      ovf <= (push & full & ~pop) | (ovf & ~ovf_clr);
    end
  always_ff @(posedge cpu_clock)
    if (wr) mem[wp] <= ent;
endmodule

// File: tb/tb_snd_wrqueue.sv
// tb_snd_wrqueue: randomized and directed check of snd_wrqueue against a queue model
module tb_snd_wrqueue;
  localparam int NCHAN = 8;
  localparam int DEPTH = 4;
  localparam logic [5:0] VOLBASE = 6'h06;
  localparam int CW = 3;
  localparam int LW = 3;
  logic cpu_clock = 0, rst_n = 0;
  logic [15:0] a = 0;
  logic [7:0] din = 0;
  logic iorq_n = 1, mreq_n = 1, rd_n = 1, wr_n = 1, mode_full = 1, ovf_clr = 0, q_ready = 0;
  logic [LW-1:0] q_level;
  logic full, empty, ovf;
  int checks = 0, errors = 0;
  snd_wrqueue_if #(.CW(CW)) q ();
  assign q.q_ready = q_ready;
  snd_wrqueue #(.NCHAN(NCHAN), .DEPTH(DEPTH), .VOLBASE(VOLBASE)) dut (
    .cpu_clock(cpu_clock), .rst_n(rst_n), .a(a), .din(din), .iorq_n(iorq_n), .mreq_n(mreq_n),
    .rd_n(rd_n), .wr_n(wr_n), .mode_full(mode_full), .ovf_clr(ovf_clr), .q(q),
    .q_level(q_level), .full(full), .empty(empty), .ovf(ovf)
  );
  always #5 cpu_clock = ~cpu_clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: queue of entries {datnvol, addr[2:0], data} as integers
  int mq[$];
  bit mpv = 0, mps = 0, movf = 0;
  always @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      mpv = 0;
      mps = 0;
      movf = 0;
    end else begin : model_step
      bit vc, sc, vp, sp, pp, drop;
      int e;
      vc = !iorq_n && !wr_n && a[7:6] == 2'b00 && int'(a[5:0]) >= int'(VOLBASE) &&
           int'(a[5:0]) < int'(VOLBASE) + NCHAN;
      sc = !mreq_n && !rd_n && a[15:13] == 3'b011;
      vp = vc && !mpv;
      sp = sc && !mps;
      mpv = vc;
      mps = sc;
      pp = mq.size() > 0 && q_ready;
      if (sp) e = 2048 + ((int'(a[15:8]) % (mode_full ? NCHAN : NCHAN / 2)) << 8) + int'(din);
      else e = ((int'(a[5:0]) - int'(VOLBASE)) << 8) + int'(din);
      drop = (vp || sp) && mq.size() == DEPTH && !pp;
      if (pp) void'(mq.pop_front());
      if ((vp || sp) && !drop) mq.push_back(e);
      if (ovf_clr) movf = 0;
      if (drop) movf = 1;
    end
  end

  always @(negedge cpu_clock) begin : compare
    int h;
    h = mq.size() > 0 ? mq[0] : 0;
    chk("q_valid", 32'(q.q_valid), 32'(mq.size() > 0));
    chk("head", 32'({q.q_datnvol, q.q_addr, q.q_data}), 32'(h));
    chk("q_level", 32'(q_level), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("ovf", 32'(ovf), 32'(movf));
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge cpu_clock);
    #2;
  endtask

  task automatic vol_wr(input logic [5:0] port, input logic [7:0] d);
    a = {8'($urandom), 2'b00, port};
    din = d;
    iorq_n = 0;
    wr_n = 0;
    step();
    iorq_n = 1;
    wr_n = 1;
    step();
  endtask

  task automatic smp_rd(input logic [15:0] addr, input logic [7:0] d);
    a = addr;
    din = d;
    mreq_n = 0;
    rd_n = 0;
    step();
    mreq_n = 1;
    rd_n = 1;
    step();
  endtask

  task automatic pop1();
    q_ready = 1;
    step();
    q_ready = 0;
  endtask

  initial begin
    step(2);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_level", 32'(q_level), 32'd0);
    rst_n = 1;
    step();
    vol_wr(6'h08, 8'h5A);
    chk("vol_level", 32'(q_level), 32'd1);
    chk("vol_head", 32'({q.q_datnvol, q.q_addr, q.q_data}), 32'h25A);
    pop1();
    smp_rd(16'h6300, 8'h80);
    chk("smp_full_head", 32'({q.q_datnvol, q.q_addr, q.q_data}), 32'hB80);
    pop1();
    mode_full = 0;
    smp_rd(16'h6700, 8'h80);
    chk("smp_half_head", 32'({q.q_datnvol, q.q_addr, q.q_data}), 32'hB80);
    pop1();
    mode_full = 1;
    for (int i = 0; i < 5; i++) vol_wr(6'(6 + i), 8'(8'h10 + i));
    chk("ovf_level", 32'(q_level), 32'd4);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_head", 32'({q.q_datnvol, q.q_addr, q.q_data}), 32'h010);
    ovf_clr = 1;
    step();
    ovf_clr = 0;
    chk("ovf_clr", 32'(ovf), 32'd0);
    a = 16'h000D;
    din = 8'hEE;
    iorq_n = 0;
    wr_n = 0;
    q_ready = 1;
    step();
    q_ready = 0;
    iorq_n = 1;
    wr_n = 1;
    chk("pp_level", 32'(q_level), 32'd4);
    chk("pp_ovf", 32'(ovf), 32'd0);
    repeat (3) pop1();
    chk("pp_last", 32'({q.q_datnvol, q.q_addr, q.q_data}), 32'h7EE);
    pop1();
    a = 16'h0007;
    din = 8'h44;
    iorq_n = 0;
    wr_n = 0;
    step(6);
    iorq_n = 1;
    wr_n = 1;
    step();
    chk("wait_level", 32'(q_level), 32'd1);
    vol_wr(6'(VOLBASE + NCHAN), 8'h99);
    chk("oor_level", 32'(q_level), 32'd1);
    pop1();
    vol_wr(6'h09, 8'h01);
    vol_wr(6'h0A, 8'h02);
    vol_wr(6'h0B, 8'h03);
    chk("pre_rst_level", 32'(q_level), 32'd3);
    #1 rst_n = 0;
    #1;
    chk("arst_valid", 32'(q.q_valid), 32'd0);
    chk("arst_level", 32'(q_level), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_head", 32'({q.q_datnvol, q.q_addr, q.q_data}), 32'h0);
    a = 16'h0009;
    din = 8'h33;
    iorq_n = 0;
    wr_n = 0;
    step();
    rst_n = 1;
    step();
    chk("rel_level", 32'(q_level), 32'd1);
    chk("rel_head", 32'({q.q_datnvol, q.q_addr, q.q_data}), 32'h333);
    step(3);
    iorq_n = 1;
    wr_n = 1;
    chk("rel_once", 32'(q_level), 32'd1);
    pop1();
    q_ready = 1;
    for (int i = 0; i < 10; i++) vol_wr(6'(6 + i % 8), 8'($urandom));
    step(2);
    chk("stream_empty", 32'(empty), 32'd1);
    q_ready = 0;
    for (int i = 0; i < 3000; i++) begin
      iorq_n = $urandom_range(0, 2) != 0;
      wr_n = $urandom_range(0, 1) != 0;
      mreq_n = $urandom_range(0, 2) != 0;
      rd_n = $urandom_range(0, 1) != 0;
      a[15:8] = $urandom_range(0, 3) != 0 ? {3'b011, 5'($urandom)} : 8'($urandom);
      a[7:0] = $urandom_range(0, 3) != 0 ? 8'($urandom_range(4, 15)) : 8'($urandom);
      din = 8'($urandom);
      q_ready = $urandom_range(0, 2) == 0;
      ovf_clr = $urandom_range(0, 15) == 0;
      mode_full = $urandom_range(0, 1) != 0;
      step();
    end
    iorq_n = 1;
    mreq_n = 1;
    rd_n = 1;
    wr_n = 1;
    ovf_clr = 0;
    q_ready = 1;
    step(DEPTH + 2);
    chk("final_empty", 32'(empty), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
